// File: rtl/mem_stimulus_sequencer.sv
// mem_stimulus_sequencer: programmable memory-coherence transaction source.
// A loadable program RAM of DEPTH entries (address, op, processor, data) is
// replayed toward the coherence model over a valid/ready handshake, with an
// optional loop back to entry 0.
// Optional feature: define SEQ_GAP_EN to add the Gap port and an idle GAP
// state between transactions.
module mem_stimulus_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int PROC_W = 2,
    parameter int DEPTH  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              LoadEn,
    input  logic [IDX_W-1:0]  LoadIndex,
    input  logic [ADDR_W-1:0] LoadAddress,
    input  logic              LoadOp,
    input  logic [PROC_W-1:0] LoadProcessor,
    input  logic [DATA_W-1:0] LoadData,
    input  logic [IDX_W:0]    Length,
    input  logic              Start,
    input  logic              Loop,
`ifdef SEQ_GAP_EN
    input  logic [3:0]        Gap,
`endif
    input  logic              TxReady,
    output logic              TxValid,
    output logic [ADDR_W-1:0] AddressTest,
    output logic              WriteOrRead,
    output logic [PROC_W-1:0] Processor,
    output logic [DATA_W-1:0] DataTest,
    output logic [IDX_W-1:0]  Index,
    output logic              Done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
`ifdef SEQ_GAP_EN
    localparam logic [1:0] S_GAP   = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE_L   = (IDX_W+1)'(1);

    // Program RAM: deliberately not reset so a program survives Resetn.
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic              mem_op   [DEPTH];
    logic [PROC_W-1:0] mem_proc [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [IDX_W:0]    len_q,   len_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              valid_q, valid_d;
    logic              done_q,  done_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              op_q,    op_d;
    logic [PROC_W-1:0] proc_q,  proc_d;
    logic [DATA_W-1:0] data_q,  data_d;
`ifdef SEQ_GAP_EN
    logic [3:0]        gap_cnt_q, gap_cnt_d;
`endif

    logic              load_ok;
    logic              hs;
    logic              last;
    logic [IDX_W-1:0]  nxt_idx;

    // Loads are only honoured while no run is in flight.
    always_comb begin
        load_ok = LoadEn && ((state_q == S_IDLE) || (state_q == S_DONE));
        hs      = valid_q && TxReady;
        last    = ({1'b0, idx_q} == (len_q - ONE_L));
        nxt_idx = last ? '0 : idx_q + 1'b1;
    end

    // Program RAM write port; a same-cycle Start reads the pre-write contents.
    always_ff @(posedge Clock) begin
        if (load_ok) begin
            mem_addr[LoadIndex] <= LoadAddress;
            mem_op[LoadIndex]   <= LoadOp;
            mem_proc[LoadIndex] <= LoadProcessor;
            mem_data[LoadIndex] <= LoadData;
        end
    end

    // Sequencer next-state: start/latch length, advance on handshake, wrap or finish.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = done_q;
        addr_d  = addr_q;
        op_d    = op_q;
        proc_d  = proc_q;
        data_d  = data_q;
`ifdef SEQ_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    len_d = (Length > DEPTH_L) ? DEPTH_L : Length;
                    if (Length == '0) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        done_d  = 1'b0;
                        addr_d  = mem_addr[0];
                        op_d    = mem_op[0];
                        proc_d  = mem_proc[0];
                        data_d  = mem_data[0];
                    end
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    if (last && !Loop) begin
                        // Fields keep the last transaction while Done is shown.
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = nxt_idx;
                        addr_d = mem_addr[nxt_idx];
                        op_d   = mem_op[nxt_idx];
                        proc_d = mem_proc[nxt_idx];
                        data_d = mem_data[nxt_idx];
`ifdef SEQ_GAP_EN
                        // Next entry is staged now and released when the gap expires.
                        if (Gap != 4'd0) begin
                            state_d   = S_GAP;
                            valid_d   = 1'b0;
                            gap_cnt_d = Gap;
                        end
`endif
                    end
                end
            end
`ifdef SEQ_GAP_EN
            S_GAP: begin
                if (gap_cnt_q == 4'd1) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset clears all visible outputs at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            proc_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            proc_q  <= proc_d;
            data_q  <= data_d;
        end
    end

`ifdef SEQ_GAP_EN
    // Gap countdown register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) gap_cnt_q <= '0;
        else         gap_cnt_q <= gap_cnt_d;
    end
`endif

    assign TxValid     = valid_q;
    assign Done        = done_q;
    assign Index       = idx_q;
    assign AddressTest = addr_q;
    assign WriteOrRead = op_q;
    assign Processor   = proc_q;
    assign DataTest    = data_q;

endmodule

// File: tb/tb_mem_stimulus_sequencer.sv
// Scoreboard bench for mem_stimulus_sequencer: the driver pushes the expected
// transaction list of each run, a monitor pops on every handshake.
module tb_mem_stimulus_sequencer;
    localparam int DEPTH = 16;

    logic       Clock, Resetn, LoadEn, LoadOp, Start, Loop, TxReady;
    logic [3:0] LoadIndex, LoadAddress, LoadData;
    logic [1:0] LoadProcessor;
    logic [4:0] Length;
`ifdef SEQ_GAP_EN
    logic [3:0] Gap;
`endif
    logic       TxValid, WriteOrRead, Done;
    logic [3:0] AddressTest, DataTest, Index;
    logic [1:0] Processor;

    mem_stimulus_sequencer #(.ADDR_W(4), .DATA_W(4), .PROC_W(2), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Resetn(Resetn), .LoadEn(LoadEn), .LoadIndex(LoadIndex),
        .LoadAddress(LoadAddress), .LoadOp(LoadOp), .LoadProcessor(LoadProcessor),
        .LoadData(LoadData), .Length(Length), .Start(Start), .Loop(Loop),
`ifdef SEQ_GAP_EN
        .Gap(Gap),
`endif
        .TxReady(TxReady), .TxValid(TxValid), .AddressTest(AddressTest),
        .WriteOrRead(WriteOrRead), .Processor(Processor), .DataTest(DataTest),
        .Index(Index), .Done(Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] a;
        logic       o;
        logic [1:0] p;
        logic [3:0] d;
        logic [3:0] i;
    } txn_t;

    txn_t m_prog [DEPTH];
    txn_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   n_hs  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the next expected entry; a held
    // transaction must not change.
    initial begin
        txn_t cur, prev, e;
        logic hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge Clock);
            if (!Resetn) begin
                hold = 1'b0;
            end else begin
                cur = {AddressTest, WriteOrRead, Processor, DataTest, Index};
                if (hold) chk("hold_stable", {16'd0, TxValid, cur}, {16'd0, 1'b1, prev});
                if (TxValid && TxReady) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_txn got=%0h want=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn", {17'd0, cur}, {17'd0, e});
                        n_hs++;
                    end
                end
                hold = TxValid && !TxReady;
                prev = cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic txn_t coh(input int k);
        // addr, op, proc, data of the coherence program
        case (k)
            0: coh = {4'd1, 1'b0, 2'd0, 4'd0, 4'd0};
            1: coh = {4'd1, 1'b1, 2'd0, 4'd3, 4'd0};
            2: coh = {4'd1, 1'b0, 2'd1, 4'd0, 4'd0};
            3: coh = {4'd2, 1'b1, 2'd1, 4'd5, 4'd0};
            4: coh = {4'd2, 1'b0, 2'd0, 4'd0, 4'd0};
            5: coh = {4'd5, 1'b1, 2'd1, 4'd8, 4'd0};
            6: coh = {4'd5, 1'b0, 2'd0, 4'd0, 4'd0};
            7: coh = {4'd1, 1'b1, 2'd2, 4'd6, 4'd0};
            default: coh = {4'd2, 1'b0, 2'd3, 4'd0, 4'd0};
        endcase
    endfunction

    task automatic drive_load(input int k, input txn_t t);
        LoadIndex = k[3:0]; LoadAddress = t.a; LoadOp = t.o;
        LoadProcessor = t.p; LoadData = t.d;
    endtask

    task automatic load(input int k, input txn_t t);
        drive_load(k, t);
        LoadEn = 1'b1;
        tick();
        LoadEn = 1'b0;
        m_prog[k] = t;
    endtask

    task automatic push_entry(input int k);
        txn_t t;
        t = m_prog[k];
        t.i = k[3:0];
        exp_q.push_back(t);
    endtask

    // Non-looping run: expect entries 0..min(len,DEPTH)-1 in order.
    task automatic start_run(input int len, input logic lp, input logic push);
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        if (push) for (int k = 0; k < n; k++) push_entry(k);
        Length = len[4:0];
        Loop = lp;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random.
    task automatic wait_done(input int budget, input int mode);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge Clock);
            if (Done) got = 1'b1;
            else begin
                @(posedge Clock);
                #1;
                case (mode)
                    0: TxReady = 1'b1;
                    1: TxReady = ((c % 3) == 2);
                    default: TxReady = 1'($urandom_range(0, 1));
                endcase
            end
        end
        chk("done_reached", {31'd0, got}, 32'd1);
        chk("valid_at_done", {31'd0, TxValid}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        TxReady = 1'b1;
    endtask

    initial begin
        txn_t t, old0;
        int base;
        bit seen;
        int lens [6];
        Resetn = 1'b0; LoadEn = 1'b0; Start = 1'b0; Loop = 1'b0; TxReady = 1'b1;
        Length = '0; LoadIndex = '0; LoadAddress = '0; LoadOp = 1'b0;
        LoadProcessor = '0; LoadData = '0;
`ifdef SEQ_GAP_EN
        Gap = 4'd0;
`endif
        #22;
        chk("reset_outs", {17'd0, TxValid, Done, Index, AddressTest, WriteOrRead, Processor, DataTest}, 32'd0);
        tick();
        Resetn = 1'b1;

        // Back-to-back coherence program: 9 valid cycles, then Done.
        for (int k = 0; k < 9; k++) load(k, coh(k));
        start_run(9, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            @(negedge Clock);
            chk("b2b_valid_done", {30'd0, TxValid, Done}, 32'd2);
        end
        @(negedge Clock);
        chk("b2b_done_next", {30'd0, TxValid, Done}, 32'd1);
        tick();

        // Ready toggled 1,0,0: entries held, none skipped or repeated.
        TxReady = 1'b1;
        start_run(9, 1'b0, 1'b1);
        wait_done(100, 1);

        // Loop over 3 entries, then drop Loop during entry 1 of a later pass.
        for (int p = 0; p < 3; p++) for (int k = 0; k < 3; k++) push_entry(k);
        base = n_hs;
        start_run(3, 1'b1, 1'b0);
        for (int c = 0; c < 40 && (n_hs - base) < 7; c++) begin
            @(negedge Clock);
            chk("loop_no_done", {31'd0, Done}, 32'd0);
        end
        @(posedge Clock);
        #1;
        Loop = 1'b0;
        wait_done(20, 0);

        // Length 0: immediate Done, no transaction.
        start_run(0, 1'b0, 1'b1);
        @(negedge Clock);
        chk("len0_done", {30'd0, TxValid, Done}, 32'd1);
        tick();

        // LoadEn while issuing is ignored; checked in this run and a rerun.
        TxReady = 1'b0;
        start_run(9, 1'b0, 1'b1);
        t = {4'hF, 1'b1, 2'd3, 4'hF, 4'd0};
        drive_load(3, t);
        LoadEn = 1'b1;
        tick(); tick(); tick();
        LoadEn = 1'b0;
        wait_done(60, 0);
        start_run(9, 1'b0, 1'b1);
        wait_done(60, 2);

        // Load and Start together at entry 0: this run sees the old entry.
        t = {4'hA, 1'b1, 2'd2, 4'hC, 4'd0};
        old0 = m_prog[0];
        drive_load(0, t);
        LoadEn = 1'b1;
        start_run(9, 1'b0, 1'b1);
        LoadEn = 1'b0;
        m_prog[0] = t;
        chk("sim_load_old", {17'd0, AddressTest, WriteOrRead, Processor, DataTest, 4'd0},
            {17'd0, old0});
        wait_done(60, 0);
        start_run(9, 1'b0, 1'b1);
        wait_done(60, 0);

        // Reset at Index 4 clears outputs at once; program survives.
        start_run(9, 1'b0, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge Clock);
            if (TxValid && Index == 4'd4) seen = 1'b1;
        end
        chk("reached_idx4", {31'd0, seen}, 32'd1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_reset_outs", {17'd0, TxValid, Done, Index, AddressTest, WriteOrRead, Processor, DataTest}, 32'd0);
        exp_q.delete();
        tick();
        Resetn = 1'b1;
        @(negedge Clock);
        chk("post_reset_idle", {30'd0, TxValid, Done}, 32'd0);
        tick();
        start_run(9, 1'b0, 1'b1);
        wait_done(60, 0);

`ifdef SEQ_GAP_EN
        // Gap 2 between transactions.
        begin
            logic [6:0] pat;
            pat = 7'b1001001;
            Gap = 4'd2;
            start_run(3, 1'b0, 1'b1);
            for (int k = 6; k >= 0; k--) begin
                @(negedge Clock);
                chk("gap_pattern", {31'd0, TxValid}, {31'd0, pat[k]});
            end
            @(negedge Clock);
            chk("gap_done", {30'd0, TxValid, Done}, 32'd1);
            tick();
            Gap = 4'd0;
        end
`endif

        // Random full-depth programs, random ready, lengths incl. clamp cases.
        for (int k = 0; k < DEPTH; k++) begin
            t = txn_t'({$urandom} & 32'h7FF0);
            load(k, t);
        end
        lens[0] = 16; lens[1] = 20; lens[2] = 31; lens[3] = 1;
        lens[4] = $urandom_range(2, 15); lens[5] = $urandom_range(1, 31);
        for (int r = 0; r < 6; r++) begin
            start_run(lens[r], 1'b0, 1'b1);
            wait_done(400, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stimulus_sequencer.md
# mem_stimulus_sequencer

- Programmable transaction sequencer that drives memory-coherence test traffic (address, read/write, processor ID, data) into the directory/cache subsystem under test.
- Replaces the fixed, free-running 9-entry stimulus list with a loadable program RAM, parametrised field widths and depth, a valid/ready handshake toward the consumer, and optional looping.
- Sits between the bench/host load port and the processor request inputs of the coherence model.

## Interface
Parameters:
- ADDR_W, 4, address field width
- DATA_W, 4, data field width
- PROC_W, 2, processor-ID field width
- DEPTH, 16, program entries (power of two, ≥2); IDX_W = $clog2(DEPTH)

Ports:
- Clock  in  1  single clock, all logic on rising edge
- Resetn  in  1  asynchronous, active-low reset
- LoadEn  in  1  write one program entry this cycle
- LoadIndex  in  IDX_W  entry to write
- LoadAddress / LoadOp / LoadProcessor / LoadData  in  ADDR_W / 1 / PROC_W / DATA_W  entry fields; Op 0=read, 1=write
- Length  in  IDX_W+1  number of entries to run, sampled on Start
- Start  in  1  begin a run
- Loop  in  1  restart at entry 0 after the last entry instead of finishing
- Gap  in  4  idle cycles between transactions (only with SEQ_GAP_EN)
- TxReady  in  1  consumer accepts current transaction
- TxValid  out  1  transaction fields valid
- AddressTest / WriteOrRead / Processor / DataTest  out  ADDR_W / 1 / PROC_W / DATA_W  current transaction
- Index  out  IDX_W  program index of current transaction
- Done  out  1  run complete

## Operation
- States: IDLE, ISSUE, GAP (only with SEQ_GAP_EN), DONE.
- Program RAM is not reset. Load is accepted only in IDLE or DONE. LoadEn in ISSUE/GAP is ignored.
- IDLE/DONE + Start:
  - Latch Length.
  - Length==0 → DONE.
  - Otherwise Index=0, present entry 0, go to ISSUE. Done clears.
- ISSUE: TxValid=1, and the fields stay stable until TxValid&TxReady. On handshake:
  - Index==Length−1 and Loop=0 → DONE.
  - Index==Length−1 and Loop=1 → Index=0.
  - Otherwise Index+1.
  - Go to GAP instead of presenting the next entry if SEQ_GAP_EN and Gap≠0.
- Loop is sampled at each last-entry handshake, so deasserting Loop mid-run ends the run at the next wrap.
- DONE: Done=1, TxValid=0, fields hold the last transaction, until Start.
- Start in ISSUE/GAP is ignored.
- Length>DEPTH is clamped to DEPTH.

## Timing
- Reset values: TxValid=0, Done=0, Index=0, AddressTest=0, WriteOrRead=0, Processor=0, DataTest=0, state IDLE.
- All outputs are registered.
- Start at edge N → TxValid=1 with entry 0 after edge N (visible in cycle N+1).
- Handshake at edge M → next entry presented after edge M. Throughput is one transaction per cycle while TxReady=1.
- Last handshake at edge M (Loop=0) → TxValid=0, Done=1 after edge M.
- Load at edge K → the entry is readable by a run started at edge K+1 or later.
- Simultaneous LoadEn and Start in IDLE: the write completes, and a run starting at that same index sees the old value.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronously), and the program RAM is preserved.

## Configuration
- SEQ_GAP_EN defined:
  - After each handshake that does not end the run, enter GAP with TxValid=0 for exactly Gap cycles, then ISSUE with the next entry.
  - Gap is sampled at the handshake.
  - Gap=0 behaves as back-to-back.
- SEQ_GAP_EN undefined: no GAP state, Gap port absent, always back-to-back.

## Test plan
- Load the 9-entry coherence program (entry 0: addr 1, read, P0, data 0; … entry 5: addr 5, write, P1, data 8), Length=9, Loop=0, TxReady=1, Start → 9 consecutive valid cycles matching entries 0–8, then Done=1 with TxValid=0 in the next cycle.
- Same program, TxReady toggled 1,0,0,1,… → each entry is held stable while TxReady=0 and none is skipped or duplicated; Index tracks 0..8.
- Length=3, Loop=1, TxReady=1 → Index sequence 0,1,2,0,1,2…; Done stays 0. Drop Loop during entry 1 → run ends after entry 2, Done=1.
- Length=0, Start → Done=1 one cycle later with TxValid never asserted. LoadEn during ISSUE with a different value → RAM unchanged, checked on rerun.
- Reset pulse mid-run at Index=4 → all outputs 0 immediately. Start without reload → original program replays from entry 0.
- SEQ_GAP_EN, Gap=2, Length=3, TxReady=1 → TxValid pattern 1,0,0,1,0,0,1, then Done.
